// File: rtl/mnist_infer_sched.sv
// mnist_infer_sched
//   Inference scheduler between the board run button / switches and the MNIST
//   accelerator. Debounces the run button, selects a single image or sweeps
//   all stored images, drives the image-load and start handshakes, waits for
//   done under a watchdog and scores each prediction against its label.
//
//   Optional feature: define SCHED_PERF_EN to add perf_cycles, a saturating
//   count of busy cycles for the last accepted batch.
//
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   btn_run       raw asynchronous run button
//   mode_cont     1 = sweep all images, 0 = single image (sampled at accept)
//   img_sel_sw    single-mode image index (sampled at accept)
//   exp_label     label of image img_sel (combinational from top level)
//   accel_done    accelerator done level; accel_pred valid while high
//   accel_pred    accelerator predicted digit
//   img_sel       current image index
//   img_load      image-load strobe, held LOAD_CYC cycles
//   accel_start   one-cycle start pulse
//   busy          high in any state other than IDLE
//   batch_done    one-cycle pulse at batch end
//   last_pred     last latched prediction
//   pass          last_pred matched its image label
//   run_cnt       images completed in the current batch
//   correct_cnt   passes in the current batch
//   timeout_err   watchdog expired; sticky until the next accepted run
//   perf_cycles   (SCHED_PERF_EN only) busy cycles of the last batch
module mnist_infer_sched #(
  parameter int NUM_IMG      = 4,
  parameter int IDX_W        = 2,
  parameter int DEBOUNCE_CYC = 16,
  parameter int LOAD_CYC     = 2,
  parameter int TIMEOUT_CYC  = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_run,
  input  logic             mode_cont,
  input  logic [IDX_W-1:0] img_sel_sw,
  input  logic [3:0]       exp_label,
  input  logic             accel_done,
  input  logic [3:0]       accel_pred,
  output logic [IDX_W-1:0] img_sel,
  output logic             img_load,
  output logic             accel_start,
  output logic             busy,
  output logic             batch_done,
  output logic [3:0]       last_pred,
  output logic             pass,
  output logic [IDX_W:0]   run_cnt,
  output logic [IDX_W:0]   correct_cnt,
  output logic             timeout_err
`ifdef SCHED_PERF_EN
  ,
  output logic [23:0]      perf_cycles
`endif
);

  localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);
  localparam int LD_W = $clog2(LOAD_CYC + 1);
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IDX_W-1:0] LAST_IMG = IDX_W'(NUM_IMG - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_WAIT, S_CHECK, S_NEXT, S_FINISH
  } state_t;

  state_t            state;
  logic [1:0]        btn_sync;
  logic [DB_W-1:0]   db_cnt;
  logic              db_level;
  logic              run_req;
  logic              done_q;
  logic              done_rise;
  logic              mode_q;
  logic [LD_W-1:0]   load_cnt;
  logic [WD_W-1:0]   wd_cnt;

  // Button synchronizer and debouncer; run_req pulses on an accepted 0->1.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_sync <= '0;
      db_cnt   <= '0;
      db_level <= 1'b0;
      run_req  <= 1'b0;
    end else begin
      btn_sync <= {btn_sync[0], btn_run};
      run_req  <= 1'b0;
      if (btn_sync[1] == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_W'(DEBOUNCE_CYC - 1)) begin
        db_level <= btn_sync[1];
        db_cnt   <= '0;
        run_req  <= btn_sync[1];
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) done_q <= 1'b0;
    else     done_q <= accel_done;
  end

  assign done_rise = accel_done & ~done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      mode_q      <= 1'b0;
      load_cnt    <= '0;
      wd_cnt      <= '0;
      img_sel     <= '0;
      img_load    <= 1'b0;
      accel_start <= 1'b0;
      busy        <= 1'b0;
      batch_done  <= 1'b0;
      last_pred   <= '0;
      pass        <= 1'b0;
      run_cnt     <= '0;
      correct_cnt <= '0;
      timeout_err <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (run_req) begin
            img_sel     <= mode_cont ? '0 : img_sel_sw;
            mode_q      <= mode_cont;
            run_cnt     <= '0;
            correct_cnt <= '0;
            timeout_err <= 1'b0;
            load_cnt    <= '0;
            img_load    <= 1'b1;
            busy        <= 1'b1;
            state       <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (load_cnt == LD_W'(LOAD_CYC - 1)) begin
            img_load    <= 1'b0;
            accel_start <= 1'b1;
            state       <= S_START;
          end else begin
            load_cnt <= load_cnt + 1'b1;
          end
        end
        S_START: begin
          accel_start <= 1'b0;
          wd_cnt      <= '0;
          state       <= S_WAIT;
        end
        S_WAIT: begin
          if (done_rise) begin
            last_pred <= accel_pred;
            pass      <= (accel_pred == exp_label);
            state     <= S_CHECK;
          end else if (wd_cnt == WD_W'(TIMEOUT_CYC - 2)) begin
            // This cycle's increment would reach TIMEOUT_CYC-1: expire now.
            timeout_err <= 1'b1;
            batch_done  <= 1'b1;
            state       <= S_FINISH;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        S_CHECK: begin
          run_cnt     <= run_cnt + 1'b1;
          correct_cnt <= correct_cnt + (IDX_W+1)'(pass);
          if (mode_q && (img_sel != LAST_IMG)) begin
            state <= S_NEXT;
          end else begin
            batch_done <= 1'b1;
            state      <= S_FINISH;
          end
        end
        S_NEXT: begin
          img_sel  <= img_sel + 1'b1;
          load_cnt <= '0;
          img_load <= 1'b1;
          state    <= S_LOAD;
        end
        S_FINISH: begin
          batch_done <= 1'b0;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef SCHED_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cycles <= '0;
    end else if ((state == S_IDLE) && run_req) begin
      perf_cycles <= '0;
    end else if (busy && (perf_cycles != '1)) begin
      perf_cycles <= perf_cycles + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mnist_infer_sched.sv
module tb_mnist_infer_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_run = 1'b0;
  logic       mode_cont = 1'b0;
  logic [1:0] img_sel_sw = '0;
  logic [3:0] exp_label;
  logic       accel_done = 1'b0;
  logic [3:0] accel_pred = '0;
  logic [1:0] img_sel;
  logic       img_load, accel_start, busy, batch_done, pass, timeout_err;
  logic [3:0] last_pred;
  logic [2:0] run_cnt, correct_cnt;
`ifdef SCHED_PERF_EN
  logic [23:0] perf_cycles;
`endif

  mnist_infer_sched #(
    .NUM_IMG(4), .IDX_W(2), .DEBOUNCE_CYC(4), .LOAD_CYC(2), .TIMEOUT_CYC(64)
  ) dut (
    .clk(clk), .rst(rst), .btn_run(btn_run), .mode_cont(mode_cont),
    .img_sel_sw(img_sel_sw), .exp_label(exp_label), .accel_done(accel_done),
    .accel_pred(accel_pred), .img_sel(img_sel), .img_load(img_load),
    .accel_start(accel_start), .busy(busy), .batch_done(batch_done),
    .last_pred(last_pred), .pass(pass), .run_cnt(run_cnt),
    .correct_cnt(correct_cnt), .timeout_err(timeout_err)
`ifdef SCHED_PERF_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Image label ROM as seen by the top level.
  logic [3:0] lbl [4] = '{4'd3, 4'd5, 4'd6, 4'd9};
  assign exp_label = lbl[img_sel];

  // Accelerator model: done rises model_lat cycles after a start.
  bit         model_en = 1'b1;
  int         model_lat = 50;
  logic [3:0] pred_tab [4] = '{4'd3, 4'd5, 4'd6, 4'd9};
  int         m_cnt = 0;
  bit         m_run = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      accel_done <= 1'b0;
      m_run      <= 1'b0;
      m_cnt      <= 0;
    end else if (accel_start) begin
      accel_done <= 1'b0;
      m_run      <= model_en;
      m_cnt      <= 0;
    end else if (m_run) begin
      if (m_cnt == model_lat - 1) begin
        accel_done <= 1'b1;
        accel_pred <= pred_tab[img_sel];
        m_run      <= 1'b0;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  // Event monitor, sampled on the falling edge.
  int cyc = 0;
  always @(posedge clk) cyc++;

  int   n_start = 0, n_bd = 0, n_rise = 0, busy_cnt = 0, bd_cyc = 0;
  int   start_cyc [64];
  int   start_img [64];
  int   rise_cyc  [64];
  logic done_prev = 1'b0;

  always @(negedge clk) begin
    if (accel_start) begin
      if (n_start < 64) begin
        start_cyc[n_start] = cyc;
        start_img[n_start] = int'(img_sel);
      end
      n_start++;
    end
    if (accel_done && !done_prev) begin
      if (n_rise < 64) rise_cyc[n_rise] = cyc;
      n_rise++;
    end
    done_prev = accel_done;
    if (batch_done) begin
      n_bd++;
      bd_cyc = cyc;
    end
    if (busy) busy_cnt++;
  end

  task automatic press(input int n);
    @(negedge clk);
    btn_run = 1'b1;
    repeat (n) @(negedge clk);
    btn_run = 1'b0;
  endtask

  task automatic wait_bd(input int base, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (n_bd > base) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    int b_s;
    logic [17:0] outs;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    b_s = n_start;
    outs = {img_sel, img_load, accel_start, busy, batch_done, last_pred,
            pass, run_cnt, correct_cnt, timeout_err};
    checks++;
    if (outs !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h want=0", outs);
    end
    repeat (100) @(negedge clk);
    checks++;
    if (n_start != b_s || busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_no_start starts=%0d busy=%b want 0/0", n_start - b_s, busy);
    end
  endtask

  task automatic test_debounce;
    int b_s, b_bd;
    b_s = n_start;
    b_bd = n_bd;
    mode_cont = 1'b0;
    img_sel_sw = 2'd0;
    model_en = 1'b1;
    model_lat = 20;
    press(3);
    repeat (30) @(negedge clk);
    checks++;
    if (n_start != b_s || busy !== 1'b0) begin
      failures++;
      $display("FAIL glitch_ignored starts=%0d busy=%b want 0/0", n_start - b_s, busy);
    end
    press(200);
    repeat (30) @(negedge clk);
    checks++;
    if (n_start - b_s != 1) begin
      failures++;
      $display("FAIL hold_one_start got=%0d want=1", n_start - b_s);
    end
    checks++;
    if (n_bd - b_bd != 1) begin
      failures++;
      $display("FAIL hold_one_batch got=%0d want=1", n_bd - b_bd);
    end
  endtask

  task automatic test_single;
    int b_bd, b_busy;
    bit ok;
    b_bd = n_bd;
    b_busy = busy_cnt;
    mode_cont = 1'b0;
    img_sel_sw = 2'd2;
    model_en = 1'b1;
    model_lat = 50;
    pred_tab = '{4'd3, 4'd5, 4'd6, 4'd9};
    press(10);
    // Changes after acceptance must be ignored.
    img_sel_sw = 2'd0;
    mode_cont = 1'b1;
    wait_bd(b_bd, 300, ok);
    repeat (3) @(negedge clk);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL single_timeout no batch_done within budget");
    end
    checks++;
    if (img_sel !== 2'd2 || last_pred !== 4'd6 || pass !== 1'b1) begin
      failures++;
      $display("FAIL single_result img=%0d pred=%0d pass=%b want 2/6/1", img_sel, last_pred, pass);
    end
    checks++;
    if (run_cnt !== 3'd1 || correct_cnt !== 3'd1 || n_bd - b_bd != 1) begin
      failures++;
      $display("FAIL single_counts run=%0d corr=%0d bd=%0d want 1/1/1", run_cnt, correct_cnt, n_bd - b_bd);
    end
`ifdef SCHED_PERF_EN
    checks++;
    if (perf_cycles !== 24'(busy_cnt - b_busy)) begin
      failures++;
      $display("FAIL perf_cycles got=%0d want=%0d", perf_cycles, busy_cnt - b_busy);
    end
`endif
    mode_cont = 1'b0;
  endtask

  task automatic test_sweep;
    int b_s, b_r, b_bd;
    bit ok;
    b_s = n_start;
    b_r = n_rise;
    b_bd = n_bd;
    mode_cont = 1'b1;
    model_en = 1'b1;
    model_lat = 10;
    pred_tab = '{4'd3, 4'd4, 4'd6, 4'd9};
    press(10);
    wait_bd(b_bd, 500, ok);
    repeat (3) @(negedge clk);
    checks++;
    if (!ok || n_start - b_s != 4) begin
      failures++;
      $display("FAIL sweep_starts got=%0d want=4 ok=%b", n_start - b_s, ok);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (start_img[b_s + k] != k) begin
        failures++;
        $display("FAIL sweep_img[%0d] got=%0d want=%0d", k, start_img[b_s + k], k);
      end
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (start_cyc[b_s + k + 1] - rise_cyc[b_r + k] != 5) begin
        failures++;
        $display("FAIL sweep_gap[%0d] got=%0d want=5", k,
                 start_cyc[b_s + k + 1] - rise_cyc[b_r + k]);
      end
    end
    checks++;
    if (run_cnt !== 3'd4 || correct_cnt !== 3'd3 || img_sel !== 2'd3 || pass !== 1'b1) begin
      failures++;
      $display("FAIL sweep_counts run=%0d corr=%0d img=%0d pass=%b want 4/3/3/1",
               run_cnt, correct_cnt, img_sel, pass);
    end
    mode_cont = 1'b0;
    pred_tab = '{4'd3, 4'd5, 4'd6, 4'd9};
  endtask

  task automatic test_timeout;
    int b_bd;
    bit ok;
    b_bd = n_bd;
    mode_cont = 1'b0;
    img_sel_sw = 2'd1;
    model_en = 1'b0;
    press(10);
    wait_bd(b_bd, 300, ok);
    repeat (2) @(negedge clk);
    checks++;
    if (!ok || timeout_err !== 1'b1 || run_cnt !== 3'd0) begin
      failures++;
      $display("FAIL timeout_flag ok=%b err=%b run=%0d want 1/1/0", ok, timeout_err, run_cnt);
    end
    checks++;
    if (bd_cyc - start_cyc[n_start - 1] != 64) begin
      failures++;
      $display("FAIL timeout_latency got=%0d want=64", bd_cyc - start_cyc[n_start - 1]);
    end
    model_en = 1'b1;
    model_lat = 20;
    b_bd = n_bd;
    press(10);
    wait_bd(b_bd, 300, ok);
    repeat (2) @(negedge clk);
    checks++;
    if (!ok || timeout_err !== 1'b0 || run_cnt !== 3'd1) begin
      failures++;
      $display("FAIL timeout_cleared ok=%b err=%b run=%0d want 1/0/1", ok, timeout_err, run_cnt);
    end
  endtask

  task automatic test_interference;
    int b_s, b_bd;
    bit ok;
    logic [17:0] outs;
    b_s = n_start;
    b_bd = n_bd;
    mode_cont = 1'b0;
    img_sel_sw = 2'd3;
    model_en = 1'b1;
    model_lat = 50;
    press(10);
    repeat (5) @(negedge clk);
    press(10);
    wait_bd(b_bd, 300, ok);
    repeat (40) @(negedge clk);
    checks++;
    if (!ok || n_start - b_s != 1 || run_cnt !== 3'd1 || n_bd - b_bd != 1) begin
      failures++;
      $display("FAIL midrun_press starts=%0d run=%0d bd=%0d want 1/1/1",
               n_start - b_s, run_cnt, n_bd - b_bd);
    end
    // Reset while waiting for done.
    b_s = n_start;
    press(10);
    for (int i = 0; i < 100 && n_start == b_s; i++) @(negedge clk);
    checks++;
    if (n_start == b_s) begin
      failures++;
      $display("FAIL rst_run_start no accel_start within budget");
    end
    repeat (5) @(negedge clk);
    b_bd = n_bd;
    rst = 1'b1;
    @(posedge clk);
    #1;
    outs = {img_sel, img_load, accel_start, busy, batch_done, last_pred,
            pass, run_cnt, correct_cnt, timeout_err};
    checks++;
    if (outs !== '0) begin
      failures++;
      $display("FAIL rst_in_wait got=%h want=0", outs);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (80) @(negedge clk);
    checks++;
    if (n_bd != b_bd || busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_no_batch_done bd=%0d busy=%b want 0/0", n_bd - b_bd, busy);
    end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_single();
    test_sweep();
    test_timeout();
    test_interference();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mnist_infer_sched.md
Name: mnist_infer_sched

Overview:
- Inference scheduler that sits between the board buttons/switches and the MNIST accelerator inside the FPGA top level.
- Debounces the run button and selects test images: a single image from the switches, or a sweep over all stored images.
- Drives image-load and start handshakes into the accelerator, waits for done with a watchdog, checks each prediction against its label, and keeps pass/run counters for LED display.

Parameters:
NUM_IMG, 4, number of stored test images (indices 0..NUM_IMG-1)
IDX_W, 2, width of image index; must satisfy 2**IDX_W >= NUM_IMG
DEBOUNCE_CYC, 16, consecutive stable cycles required to accept a button level change
LOAD_CYC, 2, cycles img_load is held before accel_start
TIMEOUT_CYC, 4096, WAIT-state cycle limit before declaring a timeout

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
btn_run  in  1  raw asynchronous run button
mode_cont  in  1  1 = sweep all images; 0 = single image; sampled at run acceptance
img_sel_sw  in  IDX_W  single-mode image index; sampled at run acceptance
exp_label  in  4  expected label of image img_sel; combinational from top, valid while img_sel is stable
accel_done  in  1  accelerator done; level, may stay high between runs
accel_pred  in  4  accelerator predicted digit; valid when accel_done is high
img_sel  out  IDX_W  current image index
img_load  out  1  image-load strobe to top-level image mux
accel_start  out  1  one-cycle start pulse to accelerator
busy  out  1  high in any state other than IDLE
batch_done  out  1  one-cycle pulse at batch end
last_pred  out  4  last latched prediction
pass  out  1  last_pred == label of its image
run_cnt  out  IDX_W+1  images completed in current batch
correct_cnt  out  IDX_W+1  passes in current batch
timeout_err  out  1  sticky until next accepted run

Behaviour:
- Reset: all outputs 0; state IDLE; synchronizer, debounce and watchdog counters 0; debounced level 0.
- Button path:
  - 2-flop synchronizer feeds the debouncer.
  - Debounced level flips only after the synchronized input differs from it for DEBOUNCE_CYC consecutive cycles; any agreeing cycle resets the count.
  - run_req = one-cycle pulse on a 0->1 transition of the debounced level.
  - run_req while busy is ignored and is not queued.
- done edge: done_q registers accel_done every cycle. done_rise = accel_done & ~done_q.
- FSM:
  - IDLE: on run_req, img_sel <= mode_cont ? 0 : img_sel_sw; latch mode; clear run_cnt, correct_cnt, timeout_err; go to LOAD.
  - LOAD: img_load = 1 for exactly LOAD_CYC cycles (internal counter); then go to START.
  - START: accel_start = 1 for this single cycle; clear watchdog; go to WAIT.
  - WAIT:
    - done_rise: latch last_pred <= accel_pred and pass <= (accel_pred == exp_label); go to CHECK.
    - Otherwise the watchdog increments. When it reaches TIMEOUT_CYC-1 without done_rise: timeout_err <= 1; go to FINISH; counters are not incremented.
    - If done_rise occurs in the same cycle the watchdog reaches its limit, done wins.
  - CHECK: run_cnt++; correct_cnt += pass. If latched mode is continuous and img_sel != NUM_IMG-1, go to NEXT; else go to FINISH.
  - NEXT: img_sel++ (never wraps; bounded by CHECK); go to LOAD.
  - FINISH: batch_done = 1 for this single cycle; go to IDLE. img_sel, last_pred, pass and counters hold until the next accepted run.
- Latency: run_req to first accel_start = 1 + LOAD_CYC cycles. accel_done rise to next accel_start in continuous mode = 3 + LOAD_CYC cycles.
- Mid-operation changes: mode_cont and img_sel_sw changes after acceptance have no effect.
- Reset mid-run: synchronous return to IDLE with reset values next edge; no batch_done emitted. The accelerator is reset by the same rst.
- Counters: width IDX_W+1 holds NUM_IMG without overflow.

Optional Feature:
- Macro SCHED_PERF_EN.
- Defined:
  - Adds output perf_cycles [23:0], cleared at run acceptance.
  - Increments every cycle while busy; saturates at 24'hFFFFFF.
  - Holds after FINISH and reads as total batch latency.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then idle: rst 2 cycles, no button → all outputs 0, busy 0, no accel_start for 100 cycles.
- Debounce (DEBOUNCE_CYC=4):
  - 3-cycle glitch on btn_run → no run.
  - Stable 10-cycle press → exactly one accel_start.
  - Holding the button high 200 cycles → no second run.
- Single mode: mode_cont=0, img_sel_sw=2, exp_label=6, accel model raises done with pred=6 after 50 cycles → img_sel=2, last_pred=6, pass=1, run_cnt=1, correct_cnt=1, one batch_done.
- Continuous sweep, NUM_IMG=4:
  - Model predicts labels correctly except image 1 → img_sel steps 0,1,2,3.
  - Exactly 4 accel_start pulses, run_cnt=4, correct_cnt=3.
  - With LOAD_CYC=2, each accel_start is 5 cycles after the preceding done rise.
- Timeout (TIMEOUT_CYC=64): accel_done never rises → timeout_err=1 and batch_done at 64 cycles after accel_start, run_cnt=0. The next run clears timeout_err.
- Interference:
  - Button press mid-run → ignored, counts unchanged.
  - rst asserted in WAIT → IDLE next cycle, outputs zero, no batch_done.
  - With SCHED_PERF_EN: perf_cycles equals the busy-cycle count of the single-mode run.
